// File: rtl/ac97_frame_tx.sv
// AC'97 serial frame transmitter: 256-bit frames, tag plus slots 1..4.
// Optional codec command path (slots 1/2) is built when AC97_CMD_EN is defined.
module ac97_frame_tx (
  input  logic        BIT_CLK,
  input  logic        RST_N,
  input  logic        en,
  input  logic [17:0] LEFT_IN,
  input  logic [17:0] RIGHT_IN,
  input  logic        cmd_valid,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        SYNC,
  output logic        SDATA_OUT,
  output logic        frame_sig
);

  logic [7:0]   r_cnt;
  logic         r_sync;
  logic         r_sdo;
  logic         r_fsig;
  logic         r_en;
  logic [17:0]  r_left;
  logic [17:0]  r_right;

  logic [7:0]   w_nxt;
  logic         w_wrap;
  logic         w_en;
  logic [17:0]  w_left;
  logic [17:0]  w_right;
  logic         w_cv;
  logic [6:0]   w_ca;
  logic [15:0]  w_cd;
  logic [15:0]  w_tag;
  logic [255:0] w_frame;

  assign w_nxt  = r_cnt + 8'd1;
  assign w_wrap = (r_cnt == 8'hFF);

  // On the wrap edge the frame being started uses the live inputs,
  // which are captured into the snapshot on that same edge.
  assign w_en    = w_wrap ? en       : r_en;
  assign w_left  = w_wrap ? LEFT_IN  : r_left;
  assign w_right = w_wrap ? RIGHT_IN : r_right;

`ifdef AC97_CMD_EN
  logic        r_pend;
  logic [6:0]  r_pa;
  logic [15:0] r_pd;
  logic        r_cv;
  logic [6:0]  r_ca;
  logic [15:0] r_cd;
  logic        w_acc;

  assign cmd_ready = ~r_pend;
  assign w_acc     = cmd_valid & ~r_pend;

  always_ff @(posedge BIT_CLK) begin
    if (!RST_N) begin
      r_pend <= 1'b0;
      r_pa   <= '0;
      r_pd   <= '0;
      r_cv   <= 1'b0;
      r_ca   <= '0;
      r_cd   <= '0;
    end else begin
      if (w_wrap) begin
        r_cv <= r_pend;
        r_ca <= r_pa;
        r_cd <= r_pd;
      end
      if (w_acc) begin
        r_pend <= 1'b1;
        r_pa   <= cmd_addr;
        r_pd   <= cmd_data;
      end else if (w_wrap) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign w_cv = w_wrap ? r_pend : r_cv;
  assign w_ca = w_wrap ? r_pa   : r_ca;
  assign w_cd = w_wrap ? r_pd   : r_cd;
`else
  logic w_unused;

  assign w_unused  = ^{cmd_valid, cmd_addr, cmd_data};
  assign cmd_ready = 1'b0;
  assign w_cv      = 1'b0;
  assign w_ca      = '0;
  assign w_cd      = '0;
`endif

  assign w_tag = {w_en, w_cv, w_cv, w_en, w_en, 11'd0};

  assign w_frame = {
    w_tag,
    1'b0, w_ca, 12'd0,
    w_cd, 4'd0,
    w_left, 2'd0,
    w_right, 2'd0,
    160'd0
  };

  always_ff @(posedge BIT_CLK) begin
    if (!RST_N) begin
      r_cnt   <= 8'hFF;
      r_sync  <= 1'b0;
      r_sdo   <= 1'b0;
      r_fsig  <= 1'b0;
      r_en    <= 1'b0;
      r_left  <= '0;
      r_right <= '0;
    end else begin
      r_cnt  <= w_nxt;
      r_sync <= (w_nxt < 8'd16);
      r_sdo  <= w_frame[~w_nxt];
      r_fsig <= (w_nxt == 8'hFF);
      if (w_wrap) begin
        r_en    <= en;
        r_left  <= LEFT_IN;
        r_right <= RIGHT_IN;
      end
    end
  end

  assign SYNC      = r_sync;
  assign SDATA_OUT = r_sdo;
  assign frame_sig = r_fsig;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Scoreboard bench for ac97_frame_tx: a slot-level frame model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_ac97_frame_tx;

`ifdef AC97_CMD_EN
  localparam bit CMD = 1'b1;
`else
  localparam bit CMD = 1'b0;
`endif

  logic        BIT_CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        en = 1'b0;
  logic [17:0] LEFT_IN = '0;
  logic [17:0] RIGHT_IN = '0;
  logic        cmd_valid = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready;
  logic        SYNC;
  logic        SDATA_OUT;
  logic        frame_sig;

  int checks = 0;
  int failures = 0;

  ac97_frame_tx dut (
    .BIT_CLK(BIT_CLK),
    .RST_N(RST_N),
    .en(en),
    .LEFT_IN(LEFT_IN),
    .RIGHT_IN(RIGHT_IN),
    .cmd_valid(cmd_valid),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .SYNC(SYNC),
    .SDATA_OUT(SDATA_OUT),
    .frame_sig(frame_sig)
  );

  always #5 BIT_CLK = ~BIT_CLK;

  typedef struct {
    bit sync;
    bit sdo;
    bit fs;
    bit rdy;
    int k;
  } exp_t;

  exp_t q[$];

  // reference state
  int          m_k = 255;
  bit          m_pend;
  bit [6:0]    m_pa;
  bit [15:0]   m_pd;
  bit          s_en;
  bit          s_cv;
  bit [6:0]    s_ca;
  bit [15:0]   s_cd;
  bit [17:0]   s_l;
  bit [17:0]   s_r;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s k=%0d actual=%0h required=%0h", nm, k, act, req);
    end
  endtask

  function automatic bit exp_bit(int k);
    int s;
    int b;
    bit [19:0] v;
    if (k < 16) begin
      case (15 - k)
        15, 12, 11: return s_en;
        14, 13:     return s_cv;
        default:    return 1'b0;
      endcase
    end
    s = (k - 16) / 20 + 1;
    b = 19 - (k - 16) % 20;
    case (s)
      1:       v = s_cv ? {1'b0, s_ca, 12'h000} : 20'h0;
      2:       v = s_cv ? {s_cd, 4'h0} : 20'h0;
      3:       v = {s_l, 2'b00};
      4:       v = {s_r, 2'b00};
      default: v = 20'h0;
    endcase
    return v[b];
  endfunction

  always @(posedge BIT_CLK) begin
    exp_t e;
    bit   acc;
    if (!RST_N) begin
      m_k = 255;
      m_pend = 0;
      m_pa = 0;
      m_pd = 0;
      s_en = 0;
      s_cv = 0;
      s_ca = 0;
      s_cd = 0;
      s_l = 0;
      s_r = 0;
      e.sync = 0;
      e.sdo = 0;
      e.fs = 0;
    end else begin
      acc = CMD && cmd_valid && !m_pend;
      m_k = (m_k + 1) % 256;
      if (m_k == 0) begin
        s_en = en;
        s_l = LEFT_IN;
        s_r = RIGHT_IN;
        s_cv = m_pend;
        s_ca = m_pend ? m_pa : 7'h0;
        s_cd = m_pend ? m_pd : 16'h0;
        m_pend = 0;
      end
      if (acc) begin
        m_pend = 1;
        m_pa = cmd_addr;
        m_pd = cmd_data;
      end
      e.sync = (m_k < 16);
      e.sdo = exp_bit(m_k);
      e.fs = (m_k == 255);
    end
    e.rdy = CMD && !m_pend;
    e.k = m_k;
    q.push_back(e);
  end

  int mon_cyc = 0;
  int last_fs = -1;

  always @(negedge BIT_CLK) begin
    exp_t e;
    mon_cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("SYNC", e.k, 32'(SYNC), 32'(e.sync));
      chk("SDATA_OUT", e.k, 32'(SDATA_OUT), 32'(e.sdo));
      chk("frame_sig", e.k, 32'(frame_sig), 32'(e.fs));
      chk("cmd_ready", e.k, 32'(cmd_ready), 32'(e.rdy));
    end
    if (!RST_N) begin
      last_fs = -1;
    end else if (frame_sig === 1'b1) begin
      if (last_fs >= 0)
        chk("frame_period", 255, mon_cyc - last_fs, 256);
      last_fs = mon_cyc;
    end
  end

  task automatic go_to(int k);
    int n;
    n = 0;
    do begin
      @(negedge BIT_CLK);
      n++;
    end while (m_k != k && n < 600);
    if (m_k != k) chk("go_to_timeout", k, m_k, k);
  endtask

  task automatic send_cmd(bit [6:0] a, bit [15:0] d);
    cmd_addr = a;
    cmd_data = d;
    cmd_valid = 1'b1;
    @(negedge BIT_CLK);
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] tag;
    RST_N = 1'b0;
    en = 1'b1;
    LEFT_IN = 18'h3FFFF;
    RIGHT_IN = 18'h00000;
    repeat (3) @(negedge BIT_CLK);
    RST_N = 1'b1;
    tag = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge BIT_CLK);
      tag = {tag[14:0], SDATA_OUT};
    end
    chk("first_tag", 15, 32'(tag), 32'h9800);

    go_to(59);
    LEFT_IN = 18'h00123;
    go_to(99);
    send_cmd(7'h02, 16'h8000);
    go_to(255);
    go_to(255);
    send_cmd(7'h55, 16'h1234);
    go_to(50);
    for (int i = 0; i < 5; i++) send_cmd(7'h11, 16'hBEEF);
    go_to(255);

    en = 1'b0;
    LEFT_IN = 18'h2AAAA;
    RIGHT_IN = 18'h15555;
    cmd_valid = 1'b1;
    go_to(129);
    RST_N = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge BIT_CLK);
    RST_N = 1'b1;
    en = 1'b1;
    go_to(255);

    for (int c = 0; c < 1536; c++) begin
      @(negedge BIT_CLK);
      if ($urandom_range(0, 15) == 0) LEFT_IN = 18'($urandom);
      if ($urandom_range(0, 15) == 0) RIGHT_IN = 18'($urandom);
      if ($urandom_range(0, 199) == 0) en = ~en;
      cmd_valid = ($urandom_range(0, 63) == 0);
      cmd_addr = 7'($urandom);
      cmd_data = 16'($urandom);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge BIT_CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ac97_frame_tx.md
AC97_FRAME_TX -- requirements
Module: ac97_frame_tx

Interface
REQ-001 SHALL have port BIT_CLK  input  1  AC'97 bit clock (12.288 MHz); the only clock; all logic on its rising edge.
REQ-002 SHALL have port RST_N  input  1  synchronous active-low reset, sampled on BIT_CLK rising edge.
REQ-003 SHALL have port en  input  1  audio enable; gates the frame-valid and PCM slot-valid tag bits.
REQ-004 SHALL have port LEFT_IN  input  18  PCM left sample, two's complement (square-wave generator output).
REQ-005 SHALL have port RIGHT_IN  input  18  PCM right sample, two's complement.
REQ-006 SHALL have port cmd_valid  input  1  codec register write request.
REQ-007 SHALL have port cmd_addr  input  7  codec register address.
REQ-008 SHALL have port cmd_data  input  16  codec register write data.
REQ-009 SHALL have port cmd_ready  output  1  command slot free; accept occurs when cmd_valid & cmd_ready at a rising edge.
REQ-010 SHALL have port SYNC  output  1  AC'97 frame sync, registered.
REQ-011 SHALL have port SDATA_OUT  output  1  AC'97 serial data, registered, MSB first.
REQ-012 SHALL have port frame_sig  output  1  one-cycle end-of-frame pulse that drives the downstream generator's frame counter.

Function
REQ-013 SHALL keep an 8-bit BIT_COUNT that advances by 1 per cycle and wraps 255->0; frame = 256 bits.
REQ-014 SHALL, in the cycle with BIT_COUNT==k, present frame bit k on SDATA_OUT and SYNC (both registered, zero added latency relative to BIT_COUNT).
REQ-015 SHALL drive SYNC=1 for k=0..15 and SYNC=0 for k=16..255.
REQ-016 SHALL place the tag (slot 0) at k=0..15, MSB first: tag[15]=en (frame valid), tag[14]=slot1 valid, tag[13]=slot2 valid, tag[12]=en (slot3), tag[11]=en (slot4), tag[10:0]=0.
REQ-017 SHALL place slot s (1..12) at k=16+20*(s-1) through 35+20*(s-1), MSB first.
REQ-018 SHALL send slot 1 as {1'b0 (write), cmd_addr[6:0], 12'b0} and slot 2 as {cmd_data[15:0], 4'b0} when a command is pending in the snapshot, else zeros with tag[14:13]=0.
REQ-019 SHALL send slot 3 = {LEFT,2'b00} and slot 4 = {RIGHT,2'b00} (18-bit MSB-justified into 20 bits); slots 5..12 all zero.
REQ-020 SHALL snapshot LEFT_IN, RIGHT_IN, en and the pending command on the 255->0 wrap edge; input changes mid-frame SHALL NOT affect the current frame.
REQ-021 SHALL pulse frame_sig high for exactly the cycle with BIT_COUNT==255, once per frame.
REQ-022 SHALL drive cmd_ready=1 iff no command is held in the pending register.
REQ-023 SHALL, on accept, load pending; the pending command SHALL be sent in the next frame to start and cleared on that same wrap edge, returning cmd_ready=1 in the cycle with BIT_COUNT==0.
REQ-024 SHALL, when a command is accepted on the wrap edge itself, exclude it from the frame starting then and send it in the following frame.
REQ-025 SHALL hold the command register stable while pending; cmd_valid with cmd_ready=0 SHALL be ignored.

Reset
REQ-026 SHALL, while RST_N=0, force BIT_COUNT=255, SYNC=0, SDATA_OUT=0, frame_sig=0, pending cleared, cmd_ready=1, snapshot zero.
REQ-027 SHALL begin a full frame (BIT_COUNT=0, SYNC=1) on the first edge with RST_N=1; reset mid-frame SHALL abort the frame immediately, with no partial slot resumed.

Configuration
REQ-028 SHALL compile the command path only when macro AC97_CMD_EN is defined: accept, pending register, slots 1/2 per REQ-018/023.
REQ-029 SHALL, without AC97_CMD_EN, keep all ports, hold cmd_ready=0, ignore cmd_*, send slots 1/2 and tag[14:13] as zero.

Verification
REQ-030 SHALL cover: reset release, en=1 -> SYNC high k=0..15, first tag 16'b1001_1000_0000_0000, frame_sig pulse at k=255, period 256 cycles.
REQ-031 SHALL cover: LEFT_IN=18'h3FFFF, RIGHT_IN=18'h00000 -> k=56..73 ones, 74..75 zero, 76..95 zero; change LEFT_IN at k=60 -> no effect until next frame.
REQ-032 SHALL cover (AC97_CMD_EN): cmd addr 7'h02, data 16'h8000 at k=100 -> cmd_ready=0, next frame tag 16'hF800, slot1 20'h02000, slot2 20'h80000, cmd_ready=1 at k=0.
REQ-033 SHALL cover: cmd accepted on wrap edge -> current tag[14:13]=0, command in following frame.
REQ-034 SHALL cover: en=0 -> tag 16'h0000, slots 3/4 transmitted as zero-valid; RST_N low at k=130 -> outputs 0, restart at k=0 after release.
REQ-035 SHALL cover: macro undefined -> cmd_ready=0 constant, slots 1/2 zero with cmd_valid=1.
